// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = $clog2(WIDTH) + 1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opb;
  logic [WIDTH-1:0]       a_raw;
  logic                   is_div, neg_a, neg_b, div_zero;

  logic                   accept, is_mul_f, is_div_f, sgn_f;
  logic [WIDTH:0]         mul_sum, div_part, div_diff;
  logic                   div_ge;
  logic [2*WIDTH-1:0]     mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]       quot_fix, rem_fix, hi_res, lo_res;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return n ? -sv : sv;
  endfunction

  function automatic logic signed [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return n ? -sv : sv;
  endfunction

  assign busy     = (state != IDLE);
  assign accept   = start && !flush && (state == IDLE);
  assign is_mul_f = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div_f = DIV_EN && ((funct == F_DIV) || (funct == F_DIVU));
  assign sgn_f    = (funct == F_MULT) || (funct == F_DIV);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (is_mul_f || is_div_f)) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opb});
    div_diff = div_part - {1'b0, opb};
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod_fix = cond_neg2(acc, neg_a ^ neg_b);
    quot_fix = cond_neg(acc[WIDTH-1:0], neg_a ^ neg_b);
    rem_fix  = cond_neg(acc[2*WIDTH-1:WIDTH], neg_a);
    if (!is_div) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      hi_res = a_raw;
      lo_res = {WIDTH{1'b1}};
    end else begin
      hi_res = rem_fix;
      lo_res = quot_fix;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul_f || is_div_f) begin
              cnt      <= '0;
              is_div   <= is_div_f;
              neg_a    <= sgn_f & a[WIDTH-1];
              neg_b    <= sgn_f & b[WIDTH-1];
              div_zero <= (b == '0);
              a_raw    <= a;
              acc      <= {{WIDTH{1'b0}}, (is_div_f ? magnitude(a, sgn_f) : magnitude(b, sgn_f))};
              opb      <= is_div_f ? magnitude(b, sgn_f) : magnitude(a, sgn_f);
            end else if (funct == F_MTHI) begin
              hi <= a;
            end else if (funct == F_MTLO) begin
              lo <= a;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!flush) begin
            hi   <= hi_res;
            lo   <= lo_res;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of MIPS MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        start_nd = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, busy_nd, done_nd;
  logic [31:0] hi, lo, hi_nd, lo_nd;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  muldiv_unit #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(32), .DIV_EN(1'b0)) dut_nd (
    .clk(clk), .resetn(resetn), .start(start_nd), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy_nd), .done(done_nd), .hi(hi_nd), .lo(lo_nd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = 32'd0;
    el = 32'd0;
    case (f)
      F_MULT:  begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      F_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      F_DIV, F_DIVU: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
        end else if (f == F_DIV) begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end else begin
          q = longint'({32'd0, x}) / longint'({32'd0, y});
          r = longint'({32'd0, x}) % longint'({32'd0, y});
          el = q[31:0]; eh = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input bit poke);
    int cycles;
    logic done_seen;
    model(f, x, y, exp_hi, exp_lo);
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
    cycles = 0;
    done_seen = 1'b0;
    @(negedge clk);
    while (busy && cycles < 200) begin
      cycles++;
      if (done) done_seen = 1'b1;
      if (poke && cycles == 5) begin
        start = 1'b1; funct = F_MULT; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, "_done_early"}, 64'(done_seen), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [5:0]  fsel [4];
    logic [31:0] corner [6];
    logic [31:0] rx, ry;
    logic        seen;
    fsel   = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    corner = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd3};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    resetn = 1'b1;

    run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("mult_minxmin", F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_7by2", F_DIVU, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero", F_DIV, 32'h1234_5678, 32'd0, 1'b0);
    run_op("div_zero_neg", F_DIV, 32'hF000_0001, 32'd0, 1'b0);

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; a = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi_lo", 64'(lo), 64'(exp_lo));
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    @(negedge clk);
    funct = F_MTLO; a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    start = 1'b0;
    exp_hi = 32'hA5A5_A5A5; exp_lo = 32'h5A5A_5A5A;
    check("mtlo_lo", 64'(lo), 64'(exp_lo));
    check("mtlo_hi", 64'(hi), 64'(exp_hi));
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // flush in IDLE suppresses both a move and a multiply
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = F_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    funct = F_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_hi", 64'(hi), 64'(exp_hi));
    check("idle_flush_busy", 64'(busy), 64'd0);

    // flush during CALC cycle 10
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a = 32'd123; b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("calc_flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("calc_flush_busy", 64'(busy), 64'd0);
    check("calc_flush_done", 64'(done), 64'd0);
    check("calc_flush_hi", 64'(hi), 64'(exp_hi));
    check("calc_flush_lo", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check("calc_flush_done_late", 64'(done), 64'd0);

    // flush during the FIX cycle
    @(negedge clk);
    start = 1'b1; funct = F_DIVU; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (33) @(negedge clk);
    check("fix_flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fix_flush_busy", 64'(busy), 64'd0);
    check("fix_flush_done", 64'(done), 64'd0);
    check("fix_flush_hi", 64'(hi), 64'(exp_hi));
    check("fix_flush_lo", 64'(lo), 64'(exp_lo));

    for (int i = 0; i < 30; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 0) ry = ry >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), fsel[$urandom_range(0, 3)], rx, ry, 1'b0);
    end

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a = 32'hFFFF_0001; b = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    run_op("post_rst_mult", F_MULT, 32'd9, 32'hFFFF_FFFE, 1'b0);

    // divider-less build: MTHI works, DIV is ignored
    @(negedge clk);
    start_nd = 1'b1; funct = F_MTHI; a = 32'h0000_1111;
    @(posedge clk); #1;
    start_nd = 1'b0;
    check("nd_mthi_hi", 64'(hi_nd), 64'h1111);
    @(negedge clk);
    start_nd = 1'b1; funct = F_DIV; a = 32'h1234_5678; b = 32'd0;
    @(posedge clk); #1;
    start_nd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (busy_nd || done_nd) seen = 1'b1;
    end
    check("nd_div_busy_or_done", 64'(seen), 64'd0);
    check("nd_div_hi", 64'(hi_nd), 64'h1111);
    check("nd_div_lo", 64'(lo_nd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
